// File: rtl/bits_pkg.sv
// Shared widths and FSM state type for the bit-fetch controller.
// The PF_LOAD state is used only when BITS_FETCH_PREFETCH_EN is defined.
package bits_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned OUT_W  = (1 << LEN_W) - 1;
  localparam int unsigned BUF_W  = DATA_W + OUT_W;
  localparam int unsigned CNT_W  = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    LOAD,
    PF_LOAD
  } state_t;

endpackage

// File: rtl/bits_fetch_ctrl_if.sv
// FIFO-side and consumer-side handshake bundle for bits_fetch_ctrl.
// Modport slave is the controller; modport master is the FIFO/consumer side.
interface bits_fetch_ctrl_if;
  import bits_pkg::*;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_pop;
  logic              reqin;
  logic [LEN_W-1:0]  reqlen;
  logic              reqready;
  logic              flush;
  logic              pushout;
  logic [LEN_W-1:0]  lenout;
  logic [OUT_W-1:0]  dataout;
  logic [CNT_W-1:0]  bitcount;

  modport slave (
    input  fifo_empty, fifo_dout, reqin, reqlen, flush,
    output fifo_pop, reqready, pushout, lenout, dataout, bitcount
  );

  modport master (
    output fifo_empty, fifo_dout, reqin, reqlen, flush,
    input  fifo_pop, reqready, pushout, lenout, dataout, bitcount
  );

endinterface

// File: rtl/bits_shift_buf.sv
// Residual bit buffer: valid bits are buf_q[count-1:0], oldest bit at the top.
// Append and extract may happen on the same edge; the extract then reads
// from the appended view so a straddling request is served in one step.
module bits_shift_buf
  import bits_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              append,
  input  logic              extract,
  input  logic              flush,
  input  logic [LEN_W-1:0]  n,
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  bits,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned MW = OUT_W + 1;

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] src;
  logic [BUF_W-1:0] shifted;
  logic [CNT_W-1:0] src_cnt;
  logic [CNT_W-1:0] rem_cnt;
  logic [MW-1:0]    mask;

  // Build the (optionally appended) source view and extract n bits from it
  always_comb begin
    src     = buf_q;
    src_cnt = count;
    if (append) begin
      src     = {buf_q[BUF_W-DATA_W-1:0], din};
      src_cnt = count + CNT_W'(DATA_W);
    end
    rem_cnt = src_cnt - CNT_W'(n);
    shifted = src >> rem_cnt;
    mask    = (MW'(1) << n) - MW'(1);
    bits    = shifted[OUT_W-1:0] & mask[OUT_W-1:0];
  end

  // Buffer and bit count update
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      buf_q <= '0;
      count <= '0;
    end else begin
      if (append)
        buf_q <= src;
      if (extract)
        count <= rem_cnt;
      else if (append)
        count <= src_cnt;
    end
  end

endmodule

// File: rtl/bits_fetch_ctrl.sv
// Fetch controller between a 32-bit word FIFO and a 0..15-bit MSB-first
// consumer. Optional idle prefetch is enabled by BITS_FETCH_PREFETCH_EN.
module bits_fetch_ctrl
  import bits_pkg::*;
(
  input logic              clock,
  input logic              reset,
  bits_fetch_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] ext_n;
  logic             do_append, do_extract, do_flush, push_d;
  logic             pushout_q;
  logic [LEN_W-1:0] lenout_q;
  logic [OUT_W-1:0] dataout_q;
  logic [OUT_W-1:0] ext_bits;
  logic [CNT_W-1:0] bitcount_w;
  logic             hit;

  bits_shift_buf u_buf (
    .clock   (clock),
    .reset   (reset),
    .append  (do_append),
    .extract (do_extract),
    .flush   (do_flush),
    .n       (ext_n),
    .din     (bus.fifo_dout),
    .bits    (ext_bits),
    .count   (bitcount_w)
  );

  assign hit          = CNT_W'(bus.reqlen) <= bitcount_w;
  assign bus.pushout  = pushout_q;
  assign bus.lenout   = lenout_q;
  assign bus.dataout  = dataout_q;
  assign bus.bitcount = bitcount_w;

  // Next state, handshake and buffer controls
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    ext_n          = len_q;
    do_append      = 1'b0;
    do_extract     = 1'b0;
    do_flush       = 1'b0;
    push_d         = 1'b0;
    bus.fifo_pop   = 1'b0;
    bus.reqready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.reqready = !bus.flush;
        if (bus.flush) begin
          do_flush = 1'b1;
        end else if (bus.reqin) begin
          len_d = bus.reqlen;
          if (hit) begin
            do_extract = 1'b1;
            ext_n      = bus.reqlen;
            push_d     = 1'b1;
          end else begin
            state_d = POP;
          end
        end
`ifdef BITS_FETCH_PREFETCH_EN
        else if (bitcount_w < CNT_W'(OUT_W) && !bus.fifo_empty) begin
          bus.fifo_pop = 1'b1;
          state_d      = PF_LOAD;
        end
`endif
      end
      POP: begin
        bus.fifo_pop = !bus.fifo_empty;
        if (!bus.fifo_empty)
          state_d = LOAD;
      end
      LOAD: begin
        do_append  = 1'b1;
        do_extract = 1'b1;
        push_d     = 1'b1;
        state_d    = IDLE;
      end
`ifdef BITS_FETCH_PREFETCH_EN
      PF_LOAD: begin
        do_append = 1'b1;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, latched length and registered result outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      pushout_q <= 1'b0;
      lenout_q  <= '0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pushout_q <= push_d;
      if (push_d) begin
        lenout_q  <= len_d;
        dataout_q <= ext_bits;
      end
    end
  end

endmodule

// File: tb/tb_bits_fetch_ctrl.sv
// Scoreboard bench for bits_fetch_ctrl: a bit-stream model predicts each
// result when the request is driven; the monitor compares on pushout.
module tb_bits_fetch_ctrl;
  import bits_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bits_fetch_ctrl_if bus();

  bits_fetch_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [OUT_W-1:0] data;
    int               due;
  } exp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];
  logic [31:0] fifo_q[$];
  bit          sq[$];
  int          mcnt = 0;
  int          cyc = 0;
  int          pops = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // FIFO model: data valid the cycle after a pop edge
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.fifo_pop && fifo_q.size() > 0)
      bus.fifo_dout <= fifo_q.pop_front();
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: pop legality and result scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (bus.fifo_pop) begin
        pops++;
        check_eq("pop_nonempty", bus.fifo_empty, 0);
      end
      if (bus.pushout) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_push", bus.pushout, 0);
        end else begin
          e = sb.pop_front();
          check_eq("lenout", bus.lenout, e.len);
          check_eq("dataout", bus.dataout, e.data);
          if (e.due > 0)
            check_eq("latency", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic model_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--)
      sq.push_back(w[i]);
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    model_word(w);
  endtask

  task automatic model_flush();
    for (int i = 0; i < mcnt; i++)
      void'(sq.pop_front());
    mcnt = 0;
  endtask

  // Predict the result, then present the request for one cycle
  task automatic issue(input int n, input int lat);
    exp_t e;
    logic [OUT_W-1:0] d;
    d = '0;
    check_eq("reqready_idle", bus.reqready, 1);
    if (n > mcnt)
      mcnt += 32;
    for (int i = 0; i < n; i++)
      d = {d[OUT_W-2:0], sq.pop_front()};
    mcnt -= n;
    e.len  = LEN_W'(n);
    e.data = d;
    e.due  = (lat > 0) ? cyc + lat : 0;
    sb.push_back(e);
    bus.reqin  = 1'b1;
    bus.reqlen = LEN_W'(n);
    tick();
    bus.reqin = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0)
        break;
      tick();
    end
    check_eq({tag, "_done"}, sb.size(), 0);
    sb.delete();
    check_eq({tag, "_bitcount"}, bus.bitcount, mcnt);
  endtask

  initial begin
    int p0;
    reset      = 1'b1;
    bus.reqin  = 1'b0;
    bus.reqlen = '0;
    bus.flush  = 1'b0;
    repeat (3) tick();
    check_eq("rst_pushout", bus.pushout, 0);
    check_eq("rst_pop", bus.fifo_pop, 0);
    check_eq("rst_bitcount", bus.bitcount, 0);
    reset = 1'b0;
    tick();
    check_eq("rst_reqready", bus.reqready, 1);
    check_eq("rst_lenout", bus.lenout, 0);
    check_eq("rst_dataout", bus.dataout, 0);

`ifndef BITS_FETCH_PREFETCH_EN
    // Miss from empty buffer
    push_word(32'hA5A50F0F);
    tick(); tick();
    p0 = pops;
    issue(4, 3);
    wait_done("miss");
    check_eq("miss_pops", pops - p0, 1);

    // Hit on residual bits
    p0 = pops;
    issue(15, 1);
    wait_done("hit");
    check_eq("hit_pops", pops - p0, 0);

    // Request straddling the residual and a new word
    push_word(32'hFFFF0000);
    tick(); tick();
    issue(15, 3);
    wait_done("straddle");

    // Zero-length request
    issue(0, 1);
    wait_done("zero");

    // Flush wins over a simultaneous request
    bus.flush  = 1'b1;
    bus.reqin  = 1'b1;
    bus.reqlen = 4'd4;
    #1 check_eq("flush_reqready", bus.reqready, 0);
    tick();
    bus.flush = 1'b0;
    bus.reqin = 1'b0;
    model_flush();
    tick(); tick();
    check_eq("flush_bitcount", bus.bitcount, 0);
    check_eq("flush_idle", bus.reqready, 1);

    // Stall in POP until the FIFO fills
    model_word(32'h12345678);
    issue(8, 0);
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_reqready", bus.reqready, 0);
      check_eq("stall_pop", bus.fifo_pop, 0);
      tick();
    end
    fifo_q.push_back(32'h12345678);
    if (sb.size() > 0)
      sb[0].due = cyc + 3;
    wait_done("stall");

    // Reset while waiting in POP drops the request
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    model_flush();
    bus.reqin  = 1'b1;
    bus.reqlen = 4'd4;
    tick();
    bus.reqin = 1'b0;
    tick();
    check_eq("pop_wait_ready", bus.reqready, 0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_ready", bus.reqready, 1);
    check_eq("post_rst_bitcount", bus.bitcount, 0);
    repeat (5) tick();

    // Recovery after reset
    push_word(32'h0F0F1234);
    tick(); tick();
    issue(12, 3);
    wait_done("recover");
`else
    // Idle prefetch tops up the buffer without a request
    p0 = pops;
    push_word(32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      if (bus.bitcount == 6'd32)
        break;
      tick();
    end
    check_eq("pf_bitcount", bus.bitcount, 32);
    check_eq("pf_pops", pops - p0, 1);
    mcnt = 32;
    tick();
    issue(8, 1);
    wait_done("pf_hit");
    issue(12, 1);
    wait_done("pf_hit2");
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
